// File: rtl/inst_record_table.sv
// inst_record_table
// Per-lane table of hazard records for in-flight vector instructions.
// Issue allocates a record into the lowest free slot. Writeback ORs completed
// element bits into that record's elementMask. Completion retires the record.
// Slots are never reordered. Consumers derive age from instIndex only.
//
// Ports
//   clock, reset (async, active-low)
//   alloc_*          allocate request (valid/ready) plus the captured record fields
//   upd_*            element-completion update: OR upd_mask into the matching record
//   ret_*            retire request for the matching record
//   rec_*            registered per-slot record state, slot i at [i*w +: w]
//   occupancy        registered count of valid slots
//   dup_err          sticky flag: an alloc arrived whose instIndex was already resident
//
// Configuration macro: RECORD_TABLE_AUTO_RETIRE_EN
//   When defined, a record whose elementMask becomes all-ones retires automatically
//   on the same edge that writes the last bit.
module inst_record_table #(
    parameter int NR    = 4,
    parameter int MASKW = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic                 alloc_vd_valid,
    input  logic [4:0]           alloc_vd_bits,
    input  logic                 alloc_vs1_valid,
    input  logic [4:0]           alloc_vs1_bits,
    input  logic [4:0]           alloc_vs2,
    input  logic [2:0]           alloc_instIndex,
    input  logic                 alloc_gather,
    input  logic                 alloc_gather16,
    input  logic                 alloc_onlyRead,
    input  logic                 upd_valid,
    input  logic [2:0]           upd_instIndex,
    input  logic [MASKW-1:0]     upd_mask,
    input  logic                 ret_valid,
    input  logic [2:0]           ret_instIndex,
    output logic [NR-1:0]        rec_valid,
    output logic [NR-1:0]        rec_vd_valid,
    output logic [NR*5-1:0]      rec_vd_bits,
    output logic [NR-1:0]        rec_vs1_valid,
    output logic [NR*5-1:0]      rec_vs1_bits,
    output logic [NR*5-1:0]      rec_vs2,
    output logic [NR*3-1:0]      rec_instIndex,
    output logic [NR-1:0]        rec_gather,
    output logic [NR-1:0]        rec_gather16,
    output logic [NR-1:0]        rec_onlyRead,
    output logic [NR*MASKW-1:0]  rec_elementMask,
    output logic [3:0]           occupancy,
    output logic                 dup_err
);

    logic [NR-1:0]             validQ;
    logic [NR-1:0]             vdValidQ;
    logic [NR-1:0][4:0]        vdBitsQ;
    logic [NR-1:0]             vs1ValidQ;
    logic [NR-1:0][4:0]        vs1BitsQ;
    logic [NR-1:0][4:0]        vs2Q;
    logic [NR-1:0][2:0]        instIndexQ;
    logic [NR-1:0]             gatherQ;
    logic [NR-1:0]             gather16Q;
    logic [NR-1:0]             onlyReadQ;
    logic [NR-1:0][MASKW-1:0]  maskQ;
    logic [3:0]                occupancyQ;
    logic                      dupErrQ;

    logic [NR-1:0]             retHit;
    logic [NR-1:0]             updHit;
    logic [NR-1:0]             autoRet;
    logic [NR-1:0]             freeOneHot;
    logic [NR-1:0]             allocGrant;
    logic [NR-1:0]             validNext;
    logic [NR-1:0][MASKW-1:0]  maskNext;
    logic                      dupHit;
    logic                      allocFire;
    logic [3:0]                countNext;

    // Readiness looks only at registered state, so a slot freed by a retire
    // this cycle becomes allocatable one cycle later.
    assign alloc_ready = ~&validQ;

    // Lowest clear bit of validQ, isolated as a one-hot vector.
    assign freeOneHot = ~validQ & (validQ + NR'(1));

    // Per-slot hit decode, duplicate detection and next-state for valid/mask.
    // A slot retiring this cycle does not count as a duplicate, which lets an
    // instIndex wrap around and be reused on the same edge it retires; the
    // new record then lands in a different (already free) slot.
    // Retire takes precedence over an update aimed at the same record.
    always_comb begin
        retHit    = '0;
        updHit    = '0;
        autoRet   = '0;
        dupHit    = 1'b0;
        validNext = '0;
        maskNext  = maskQ;
        countNext = '0;
        for (int i = 0; i < NR; i++) begin
            retHit[i] = ret_valid & validQ[i] & (instIndexQ[i] == ret_instIndex);
            updHit[i] = upd_valid & validQ[i] & (instIndexQ[i] == upd_instIndex) & ~retHit[i];
            if (validQ[i] && (instIndexQ[i] == alloc_instIndex) && !retHit[i]) begin
                dupHit = 1'b1;
            end
`ifdef RECORD_TABLE_AUTO_RETIRE_EN
            autoRet[i] = updHit[i] & (&(maskQ[i] | upd_mask));
`else
            autoRet[i] = 1'b0;
`endif
        end
        allocFire  = alloc_valid & alloc_ready & ~dupHit;
        allocGrant = allocFire ? freeOneHot : '0;
        for (int i = 0; i < NR; i++) begin
            if (retHit[i] || autoRet[i]) begin
                maskNext[i] = '0;
            end else if (allocGrant[i]) begin
                maskNext[i] = '0;
            end else if (updHit[i]) begin
                maskNext[i] = maskQ[i] | upd_mask;
            end
            validNext[i] = (validQ[i] & ~retHit[i] & ~autoRet[i]) | allocGrant[i];
            countNext    = countNext + 4'(validNext[i]);
        end
    end

    // Record storage. Retired slots keep stale fields; only valid and mask clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validQ     <= '0;
            vdValidQ   <= '0;
            vdBitsQ    <= '0;
            vs1ValidQ  <= '0;
            vs1BitsQ   <= '0;
            vs2Q       <= '0;
            instIndexQ <= '0;
            gatherQ    <= '0;
            gather16Q  <= '0;
            onlyReadQ  <= '0;
            maskQ      <= '0;
            occupancyQ <= '0;
            dupErrQ    <= 1'b0;
        end else begin
            validQ     <= validNext;
            maskQ      <= maskNext;
            occupancyQ <= countNext;
            dupErrQ    <= dupErrQ | (alloc_valid & alloc_ready & dupHit);
            for (int i = 0; i < NR; i++) begin
                if (allocGrant[i]) begin
                    vdValidQ[i]   <= alloc_vd_valid;
                    vdBitsQ[i]    <= alloc_vd_bits;
                    vs1ValidQ[i]  <= alloc_vs1_valid;
                    vs1BitsQ[i]   <= alloc_vs1_bits;
                    vs2Q[i]       <= alloc_vs2;
                    instIndexQ[i] <= alloc_instIndex;
                    gatherQ[i]    <= alloc_gather;
                    gather16Q[i]  <= alloc_gather16;
                    onlyReadQ[i]  <= alloc_onlyRead;
                end
            end
        end
    end

    assign rec_valid       = validQ;
    assign rec_vd_valid    = vdValidQ;
    assign rec_vd_bits     = vdBitsQ;
    assign rec_vs1_valid   = vs1ValidQ;
    assign rec_vs1_bits    = vs1BitsQ;
    assign rec_vs2         = vs2Q;
    assign rec_instIndex   = instIndexQ;
    assign rec_gather      = gatherQ;
    assign rec_gather16    = gather16Q;
    assign rec_onlyRead    = onlyReadQ;
    assign rec_elementMask = maskQ;
    assign occupancy       = occupancyQ;
    assign dup_err         = dupErrQ;

endmodule

// File: tb/tb_inst_record_table.sv
// tb_inst_record_table
// Directed bench for inst_record_table (NR=4, MASKW=256) with hand-computed
// expected values. Honours RECORD_TABLE_AUTO_RETIRE_EN for the full-mask case.
module tb_inst_record_table;

    localparam int NR    = 4;
    localparam int MASKW = 256;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic                 alloc_vd_valid;
    logic [4:0]           alloc_vd_bits;
    logic                 alloc_vs1_valid;
    logic [4:0]           alloc_vs1_bits;
    logic [4:0]           alloc_vs2;
    logic [2:0]           alloc_instIndex;
    logic                 alloc_gather;
    logic                 alloc_gather16;
    logic                 alloc_onlyRead;
    logic                 upd_valid;
    logic [2:0]           upd_instIndex;
    logic [MASKW-1:0]     upd_mask;
    logic                 ret_valid;
    logic [2:0]           ret_instIndex;
    logic [NR-1:0]        rec_valid;
    logic [NR-1:0]        rec_vd_valid;
    logic [NR*5-1:0]      rec_vd_bits;
    logic [NR-1:0]        rec_vs1_valid;
    logic [NR*5-1:0]      rec_vs1_bits;
    logic [NR*5-1:0]      rec_vs2;
    logic [NR*3-1:0]      rec_instIndex;
    logic [NR-1:0]        rec_gather;
    logic [NR-1:0]        rec_gather16;
    logic [NR-1:0]        rec_onlyRead;
    logic [NR*MASKW-1:0]  rec_elementMask;
    logic [3:0]           occupancy;
    logic                 dup_err;

    int checkCount = 0;
    int errorCount = 0;

    inst_record_table #(.NR(NR), .MASKW(MASKW)) dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_vd_valid  (alloc_vd_valid),
        .alloc_vd_bits   (alloc_vd_bits),
        .alloc_vs1_valid (alloc_vs1_valid),
        .alloc_vs1_bits  (alloc_vs1_bits),
        .alloc_vs2       (alloc_vs2),
        .alloc_instIndex (alloc_instIndex),
        .alloc_gather    (alloc_gather),
        .alloc_gather16  (alloc_gather16),
        .alloc_onlyRead  (alloc_onlyRead),
        .upd_valid       (upd_valid),
        .upd_instIndex   (upd_instIndex),
        .upd_mask        (upd_mask),
        .ret_valid       (ret_valid),
        .ret_instIndex   (ret_instIndex),
        .rec_valid       (rec_valid),
        .rec_vd_valid    (rec_vd_valid),
        .rec_vd_bits     (rec_vd_bits),
        .rec_vs1_valid   (rec_vs1_valid),
        .rec_vs1_bits    (rec_vs1_bits),
        .rec_vs2         (rec_vs2),
        .rec_instIndex   (rec_instIndex),
        .rec_gather      (rec_gather),
        .rec_gather16    (rec_gather16),
        .rec_onlyRead    (rec_onlyRead),
        .rec_elementMask (rec_elementMask),
        .occupancy       (occupancy),
        .dup_err         (dup_err)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [MASKW-1:0] observed,
                               input logic [MASKW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Let one active edge happen, settle, then drop all request strobes.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
        alloc_valid = 1'b0;
        upd_valid   = 1'b0;
        ret_valid   = 1'b0;
    endtask

    task automatic setAlloc(input logic [2:0] idx, input logic [4:0] vd);
        alloc_valid     = 1'b1;
        alloc_instIndex = idx;
        alloc_vd_valid  = 1'b1;
        alloc_vd_bits   = vd;
        alloc_vs1_valid = 1'b1;
        alloc_vs1_bits  = vd + 5'd1;
        alloc_vs2       = vd + 5'd2;
        alloc_gather    = idx[0];
        alloc_gather16  = 1'b0;
        alloc_onlyRead  = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        alloc_valid     = 1'b0;
        alloc_vd_valid  = 1'b0;
        alloc_vd_bits   = '0;
        alloc_vs1_valid = 1'b0;
        alloc_vs1_bits  = '0;
        alloc_vs2       = '0;
        alloc_instIndex = '0;
        alloc_gather    = 1'b0;
        alloc_gather16  = 1'b0;
        alloc_onlyRead  = 1'b0;
        upd_valid       = 1'b0;
        upd_instIndex   = '0;
        upd_mask        = '0;
        ret_valid       = 1'b0;
        ret_instIndex   = '0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetValid", rec_valid, 0);
        checkOutput("resetOcc", occupancy, 0);
        checkOutput("resetDup", dup_err, 0);
        checkOutput("resetReady", alloc_ready, 1);
        reset = 1'b1;

        // First alloc lands in slot 0 with a cleared mask.
        setAlloc(3'd0, 5'd8);
        applyStimulus();
        checkOutput("alloc0Valid", rec_valid, 4'b0001);
        checkOutput("alloc0Mask", rec_elementMask[0 +: MASKW], 0);
        checkOutput("alloc0Occ", occupancy, 1);
        checkOutput("alloc0Vd", rec_vd_bits[4:0], 8);
        checkOutput("alloc0Vs2", rec_vs2[4:0], 10);

        // Fill the remaining slots.
        for (int i = 1; i < 4; i++) begin
            setAlloc(3'(i), 5'(4 * i));
            applyStimulus();
        end
        checkOutput("fullValid", rec_valid, 4'b1111);
        checkOutput("fullOcc", occupancy, 4);
        checkOutput("fullReady", alloc_ready, 0);
        checkOutput("slot3Idx", rec_instIndex[9 +: 3], 3);
        checkOutput("slot3Gather", rec_gather, 4'b1010);

        // A fifth alloc is held while full.
        setAlloc(3'd4, 5'd20);
        applyStimulus();
        checkOutput("heldValid", rec_valid, 4'b1111);
        checkOutput("heldOcc", occupancy, 4);
        checkOutput("heldIdx2", rec_instIndex[6 +: 3], 2);
        checkOutput("heldDup", dup_err, 0);

        // Retire index 2; ready returns and the next alloc reuses slot 2.
        ret_valid     = 1'b1;
        ret_instIndex = 3'd2;
        applyStimulus();
        checkOutput("retValid", rec_valid, 4'b1011);
        checkOutput("retReady", alloc_ready, 1);
        checkOutput("retOcc", occupancy, 3);
        setAlloc(3'd4, 5'd20);
        applyStimulus();
        checkOutput("reuseValid", rec_valid, 4'b1111);
        checkOutput("reuseIdx", rec_instIndex[6 +: 3], 4);
        checkOutput("reuseVd", rec_vd_bits[10 +: 5], 20);

        // Two updates to index 1 accumulate.
        upd_valid     = 1'b1;
        upd_instIndex = 3'd1;
        upd_mask      = 256'hF0;
        applyStimulus();
        upd_valid     = 1'b1;
        upd_instIndex = 3'd1;
        upd_mask      = 256'h0F;
        applyStimulus();
        checkOutput("updMask1", rec_elementMask[MASKW +: MASKW], 256'hFF);
        checkOutput("updMask0", rec_elementMask[0 +: MASKW], 0);

        // Same-cycle update and retire of index 1: retire wins.
        upd_valid     = 1'b1;
        upd_instIndex = 3'd1;
        upd_mask      = 256'h100;
        ret_valid     = 1'b1;
        ret_instIndex = 3'd1;
        applyStimulus();
        checkOutput("updRetValid", rec_valid, 4'b1101);
        checkOutput("updRetMask", rec_elementMask[MASKW +: MASKW], 0);
        checkOutput("updRetOcc", occupancy, 3);

        // Duplicate alloc of resident index 3 is dropped and flagged.
        setAlloc(3'd3, 5'd30);
        applyStimulus();
        checkOutput("dupValid", rec_valid, 4'b1101);
        checkOutput("dupErr", dup_err, 1);
        checkOutput("dupOcc", occupancy, 3);
        applyStimulus();
        checkOutput("dupSticky", dup_err, 1);

        // Alloc index 3 while index 3 retires: accepted into free slot 1.
        setAlloc(3'd3, 5'd30);
        ret_valid     = 1'b1;
        ret_instIndex = 3'd3;
        applyStimulus();
        checkOutput("wrapValid", rec_valid, 4'b0111);
        checkOutput("wrapIdx1", rec_instIndex[3 +: 3], 3);
        checkOutput("wrapVd1", rec_vd_bits[5 +: 5], 30);
        checkOutput("wrapOcc", occupancy, 3);
        checkOutput("wrapDup", dup_err, 1);

        // All-ones update to index 0.
        upd_valid     = 1'b1;
        upd_instIndex = 3'd0;
        upd_mask      = '1;
        applyStimulus();
`ifdef RECORD_TABLE_AUTO_RETIRE_EN
        checkOutput("autoValid", rec_valid, 4'b0110);
        checkOutput("autoOcc", occupancy, 2);
        ret_valid     = 1'b1;
        ret_instIndex = 3'd0;
        applyStimulus();
        checkOutput("autoLateRet", rec_valid, 4'b0110);
`else
        checkOutput("fullMaskValid", rec_valid, 4'b0111);
        checkOutput("fullMaskBits", rec_elementMask[0 +: MASKW], {MASKW{1'b1}});
        checkOutput("fullMaskOcc", occupancy, 3);
`endif

        // Async reset mid-cycle with an update pending.
        upd_valid     = 1'b1;
        upd_instIndex = 3'd4;
        upd_mask      = 256'h1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstValid", rec_valid, 0);
        checkOutput("midRstOcc", occupancy, 0);
        checkOutput("midRstDup", dup_err, 0);
        checkOutput("midRstMask2", rec_elementMask[2*MASKW +: MASKW], 0);
        checkOutput("midRstReady", alloc_ready, 1);
        applyStimulus();
        reset = 1'b1;

        setAlloc(3'd5, 5'd12);
        applyStimulus();
        checkOutput("postRstValid", rec_valid, 4'b0001);
        checkOutput("postRstIdx", rec_instIndex[2:0], 5);
        checkOutput("postRstOcc", occupancy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
